program_loader: RTL and testbench

Writer side of the instruction memory. It accepts a byte stream over a valid/ready handshake, checks its length, and packs little-endian bytes into 32-bit instructions. Each instruction goes out through a synchronous write port into instruction memory. It holds the CPU in reset while loading and reports whether the stream's checksum was good. It sits between the host link (UART receiver) and the instruction memory write port.

---
 rtl/loader_pkg.sv | 6 +
 rtl/program_loader_byte_packer.sv | 24 ++
 rtl/program_loader.sv | 85 ++++++++
 tb/tb_program_loader.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the program loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
  typedef logic [15:0] len_t;
  localparam int CSUM_W = 8;
endpackage

// File: rtl/program_loader_byte_packer.sv
// byte_packer: little-endian byte-to-word assembler, flags the lane-3 byte
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        done
);
  logic [23:0] sreg;
  logic [1:0]  lane;
  assign word = {din, sreg};
  assign done = en && lane == 2'd3;
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sreg <= '0;
      lane <= '0;
    end else if (en) begin
      sreg <= {din, sreg[23:8]};
      lane <= lane + 2'd1;
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: byte-stream loader writing 32-bit words into instruction memory
module program_loader
  import loader_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic        WriteEnable,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  output logic        CpuHold,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);
  localparam int IW = $clog2(DEPTH) + 1;
  state_t state, next;
  len_t len, n_hdr;
  logic [IW-1:0] idx;
  logic [CSUM_W-1:0] csum;
  logic xfer, go, last, pk_done;
  logic [31:0] pk_word;
  assign RxReady = state inside {LEN_LO, LEN_HI, DATA, CHECK};
  assign Busy    = RxReady;
  assign CpuHold = !(state == IDLE || state == DONE);
  assign Done    = state == DONE;
  assign Error   = state == ERROR;
  assign go      = Start && state inside {IDLE, DONE, ERROR};
  assign xfer    = RxValid && RxReady;
  assign n_hdr   = {RxData, len[7:0]};
  assign last    = len_t'(idx) + 16'd1 == len;
  byte_packer u_pack (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (go),
    .en    (xfer && state == DATA),
    .din   (RxData),
    .word  (pk_word),
    .done  (pk_done)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE, ERROR: next = go ? LEN_LO : state;
      LEN_LO: next = xfer ? LEN_HI : state;
      LEN_HI: next = !xfer ? state : n_hdr > len_t'(DEPTH) ? ERROR : n_hdr == '0 ? CHECK : DATA;
      DATA:   next = pk_done && last ? CHECK : state;
      CHECK:  next = !xfer ? state : RxData == csum ? DONE : ERROR;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      len          <= '0;
      idx          <= '0;
      csum         <= '0;
      WriteEnable  <= 1'b0;
      WriteAddress <= '0;
      WriteData    <= '0;
    end else begin
      state       <= next;
      WriteEnable <= pk_done;
      if (go) begin
        len  <= '0;
        idx  <= '0;
        csum <= '0;
      end
      if (xfer && state == LEN_LO) len[7:0] <= RxData;
      if (xfer && state == LEN_HI) len[15:8] <= RxData;
      if (xfer && state == DATA) csum <= csum ^ RxData;
      if (pk_done) begin
        WriteAddress <= BASE_ADDR + 32'({idx, 2'b00});
        WriteData    <= pk_word;
        idx          <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader
module tb_program_loader;
  logic clk = 1'b0, rst_n = 1'b0, Start = 1'b0, RxValid = 1'b0;
  logic [7:0] RxData = '0;
  logic RxReady, WriteEnable, CpuHold, Busy, Done, Error;
  logic [31:0] WriteAddress, WriteData;
  int n_chk = 0, n_fail = 0, nw = 0;
  logic [31:0] wa [8], wd [8];
  always #5 clk = ~clk;
  program_loader dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .RxData(RxData), .RxValid(RxValid),
    .RxReady(RxReady), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
    .WriteData(WriteData), .CpuHold(CpuHold), .Busy(Busy), .Done(Done), .Error(Error)
  );
  always @(negedge clk) begin
    if (WriteEnable) begin
      if (nw < 8) begin
        wa[nw] = WriteAddress;
        wd[nw] = WriteData;
      end
      nw++;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    RxValid = 1'b0;
    repeat (gap) tick();
    RxData  = b;
    RxValid = 1'b1;
    while (!RxReady && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
    tick();
    RxValid = 1'b0;
  endtask
  task automatic start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask
  task automatic good_stream(input logic [7:0] last, input int maxgap);
    logic [7:0] s [11] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
    s[10] = last;
    for (int i = 0; i < 11; i++) send(s[i], maxgap == 0 ? 0 : int'($urandom_range(0, maxgap)));
  endtask
  task automatic check_writes(input string tag);
    check({tag, "_nw"}, nw, 2);
    check({tag, "_a0"}, wa[0], 32'h0);
    check({tag, "_d0"}, wd[0], 32'h0050_0093);
    check({tag, "_a1"}, wa[1], 32'h4);
    check({tag, "_d1"}, wd[1], 32'h0000_0013);
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"}, WriteEnable, 0);
    check({tag, "_wa"}, WriteAddress, 0);
    check({tag, "_wd"}, WriteData, 0);
    check({tag, "_rdy"}, RxReady, 0);
    check({tag, "_hold"}, CpuHold, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_err"}, Error, 0);
  endtask
  initial begin
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    nw = 0;
    start();
    check("start_hold", CpuHold, 1);
    check("start_busy", Busy, 1);
    check("start_ready", RxReady, 1);
    send(8'h02, 0); send(8'h00, 0);
    send(8'h93, 0); send(8'h00, 0); send(8'h50, 0); send(8'h00, 0);
    check("lat_we", WriteEnable, 1);
    check("lat_wa", WriteAddress, 32'h0);
    check("lat_wd", WriteData, 32'h0050_0093);
    send(8'h13, 0);
    check("lat_we_low", WriteEnable, 0);
    check("lat_wd_hold", WriteData, 32'h0050_0093);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'hD0, 0);
    check_writes("good");
    check("good_done", Done, 1);
    check("good_err", Error, 0);
    check("good_hold", CpuHold, 0);
    check("good_busy", Busy, 0);
    nw = 0;
    start();
    check("restart_done_clr", Done, 0);
    good_stream(8'hD1, 0);
    check_writes("bad");
    check("bad_err", Error, 1);
    check("bad_done", Done, 0);
    check("bad_hold", CpuHold, 1);
    nw = 0;
    start();
    check("empty_err_clr", Error, 0);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    check("empty_nw", nw, 0);
    check("empty_done", Done, 1);
    check("empty_err", Error, 0);
    nw = 0;
    start();
    send(8'h41, 0); send(8'h00, 0);
    check("over_err", Error, 1);
    check("over_ready", RxReady, 0);
    check("over_hold", CpuHold, 1);
    repeat (3) tick();
    check("over_nw", nw, 0);
    nw = 0;
    start();
    good_stream(8'hD0, 5);
    tick();
    check_writes("bp");
    check("bp_done", Done, 1);
    check("bp_err", Error, 0);
    nw = 0;
    start();
    send(8'h02, 0); send(8'h00, 0);
    send(8'h93, 0); send(8'h00, 0); send(8'h50, 0); send(8'h00, 0); send(8'h13, 0);
    rst_n = 1'b0;
    tick();
    check_idle_outputs("midrst");
    check("midrst_nw", nw, 1);
    rst_n = 1'b1;
    tick();
    nw = 0;
    start();
    good_stream(8'hD0, 0);
    check_writes("reload");
    check("reload_done", Done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
